// File: rtl/mcb_command_scheduler.sv
`default_nettype none
// ============================================================================
// mcb_command_scheduler : queues MCB command strobes, issues one at a time.
// Optional ISSUE timeout via MCB_SCHED_TIMEOUT_EN.            Rev 1.0
// ============================================================================
module mcb_command_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        sysClk,
  input  logic        sysRst_n,
  input  logic [7:0]  instruction_in,
  input  logic [63:0] data_in,
  input  logic        valid_camwrite_in,
  input  logic        valid_read_in,
  input  logic        valid_mem_in,
  output logic [7:0]  cmd_instr,
  output logic [63:0] cmd_data,
  output logic        cam_req,
  output logic        read_req,
  output logic        mem_req,
  input  logic        cam_ack,
  input  logic        read_ack,
  input  logic        mem_ack,
  output logic        cmd_full,
  output logic        sched_busy,
  output logic [7:0]  drop_cnt,
  output logic        timeout_err,
  input  logic        err_clear
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_EW = 2 + 8 + 64;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_ISSUE   = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [c_EW-1:0] r_fifo [FIFO_DEPTH];
  logic [c_AW:0]   r_wr_ptr, r_rd_ptr;
  logic [1:0]      r_tgt;
  logic [7:0]      r_cmd_instr;
  logic [63:0]     r_cmd_data;
  logic [7:0]      r_drop_cnt;

  logic [2:0] w_valid;
  logic [1:0] w_tgt_in;
  logic       w_empty, w_full, w_push, w_drop, w_pop, w_ack_sel, w_to_hit;

  assign w_valid  = {valid_mem_in, valid_read_in, valid_camwrite_in};
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  // Fullness is judged on the pre-pop pointers, so a same-edge pop never frees a slot.
  assign w_push   = $onehot(w_valid) && !w_full;
  assign w_drop   = (|w_valid) && !w_push;
  assign w_pop    = (r_state == S_LOAD);
  assign w_tgt_in = valid_read_in ? 2'd1 : (valid_mem_in ? 2'd2 : 2'd0);

  always_ff @(posedge sysClk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[c_AW-1:0]] <= {w_tgt_in, instruction_in, data_in};
    end
  end

  always_ff @(posedge sysClk) begin
    if (!sysRst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_drop_cnt  <= '0;
      r_tgt       <= '0;
      r_cmd_instr <= '0;
      r_cmd_data  <= '0;
      r_state     <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        {r_tgt, r_cmd_instr, r_cmd_data} <= r_fifo[r_rd_ptr[c_AW-1:0]];
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_comb begin
    w_ack_sel = 1'b0;
    case (r_tgt)
      2'd0:    w_ack_sel = cam_ack;
      2'd1:    w_ack_sel = read_ack;
      default: w_ack_sel = mem_ack;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (!w_empty) w_state_nxt = S_LOAD;
      S_LOAD:    w_state_nxt = S_ISSUE;
      S_ISSUE:   if (w_ack_sel || w_to_hit) w_state_nxt = S_RECOVER;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

`ifdef MCB_SCHED_TIMEOUT_EN
  localparam int              c_TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYCLES - 1);

  logic [c_TW-1:0] r_to_cnt;
  logic            r_timeout_err;

  // An ack on the final counted edge wins over the timeout.
  assign w_to_hit = (r_state == S_ISSUE) && !w_ack_sel && (r_to_cnt == c_TO_LAST);

  always_ff @(posedge sysClk) begin
    if (!sysRst_n) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == S_ISSUE) ? r_to_cnt + 1'b1 : '0;
      if (w_to_hit)       r_timeout_err <= 1'b1;
      else if (err_clear) r_timeout_err <= 1'b0;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = err_clear | (TIMEOUT_CYCLES > 0);
  assign w_to_hit     = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  assign cam_req    = (r_state == S_ISSUE) && (r_tgt == 2'd0);
  assign read_req   = (r_state == S_ISSUE) && (r_tgt == 2'd1);
  assign mem_req    = (r_state == S_ISSUE) && (r_tgt == 2'd2);
  assign cmd_instr  = r_cmd_instr;
  assign cmd_data   = r_cmd_data;
  assign cmd_full   = w_full;
  assign sched_busy = (r_state != S_IDLE) || !w_empty;
  assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mcb_command_scheduler.sv
`default_nettype none
// ============================================================================
// tb_mcb_command_scheduler : table-driven and directed checks of the scheduler.
// Rev 1.0
// ============================================================================
module tb_mcb_command_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  instr_in = '0;
  logic [63:0] data_in = '0;
  logic        v_cam = 1'b0, v_read = 1'b0, v_mem = 1'b0;
  logic [7:0]  cmd_instr;
  logic [63:0] cmd_data;
  logic        cam_req, read_req, mem_req;
  logic        cam_ack = 1'b0, read_ack = 1'b0, mem_ack = 1'b0;
  logic        cmd_full, sched_busy, timeout_err;
  logic        err_clear = 1'b0;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcb_command_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .sysClk(clk), .sysRst_n(rst_n),
    .instruction_in(instr_in), .data_in(data_in),
    .valid_camwrite_in(v_cam), .valid_read_in(v_read), .valid_mem_in(v_mem),
    .cmd_instr(cmd_instr), .cmd_data(cmd_data),
    .cam_req(cam_req), .read_req(read_req), .mem_req(mem_req),
    .cam_ack(cam_ack), .read_ack(read_ack), .mem_ack(mem_ack),
    .cmd_full(cmd_full), .sched_busy(sched_busy), .drop_cnt(drop_cnt),
    .timeout_err(timeout_err), .err_clear(err_clear)
  );

  // bit order for v/ack/req fields: {mem, read, cam}
  typedef struct {
    logic [2:0]  v;
    logic [2:0]  ack;
    logic [7:0]  instr;
    logic [63:0] data;
    logic [2:0]  ereq;
    logic        efull;
    logic        ebusy;
    logic [7:0]  edrop;
    logic [7:0]  einstr;
    logic [63:0] edata;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [2:0] v, input logic [2:0] ack, input logic [7:0] ins,
                     input logic [63:0] d, input logic [2:0] ereq, input logic efull,
                     input logic ebusy, input logic [7:0] edrop, input logic [7:0] eins,
                     input logic [63:0] ed);
    vec_t r;
    r.v = v; r.ack = ack; r.instr = ins; r.data = d; r.ereq = ereq; r.efull = efull;
    r.ebusy = ebusy; r.edrop = edrop; r.einstr = eins; r.edata = ed;
    vt.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    {v_mem, v_read, v_cam} = 3'b000;
    {mem_ack, read_ack, cam_ack} = 3'b000;
    instr_in = '0;
    data_in  = '0;
  endtask

  localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0000;

  initial begin
    // single mem command with ack one cycle after req
    add(3'b100, 3'b000, 8'h02, 64'hFFFF, 3'b000, 0, 1, 0, 8'h00, 64'h0);
    add(3'b000, 3'b000, 8'h00, 64'h0,    3'b000, 0, 1, 0, 8'h00, 64'h0);
    add(3'b000, 3'b000, 8'h00, 64'h0,    3'b100, 0, 1, 0, 8'h02, 64'hFFFF);
    add(3'b000, 3'b100, 8'h00, 64'h0,    3'b000, 0, 1, 0, 8'h02, 64'hFFFF);
    add(3'b000, 3'b000, 8'h00, 64'h0,    3'b000, 0, 0, 0, 8'h02, 64'hFFFF);
    // five back-to-back strobes, one dropped on full, foreign acks ignored
    add(3'b001, 3'b000, 8'h10, DB|8'h10, 3'b000, 0, 1, 0, 8'h02, 64'hFFFF);
    add(3'b010, 3'b000, 8'h11, DB|8'h11, 3'b000, 0, 1, 0, 8'h02, 64'hFFFF);
    add(3'b100, 3'b000, 8'h12, DB|8'h12, 3'b001, 0, 1, 0, 8'h10, DB|8'h10);
    add(3'b001, 3'b000, 8'h13, DB|8'h13, 3'b001, 0, 1, 0, 8'h10, DB|8'h10);
    add(3'b010, 3'b000, 8'h14, DB|8'h14, 3'b001, 1, 1, 0, 8'h10, DB|8'h10);
    add(3'b100, 3'b000, 8'h15, DB|8'h15, 3'b001, 1, 1, 1, 8'h10, DB|8'h10);
    add(3'b000, 3'b001, 8'h00, 64'h0,    3'b000, 1, 1, 1, 8'h10, DB|8'h10);
    add(3'b000, 3'b000, 8'h00, 64'h0,    3'b000, 1, 1, 1, 8'h10, DB|8'h10);
    add(3'b000, 3'b000, 8'h00, 64'h0,    3'b000, 1, 1, 1, 8'h10, DB|8'h10);
    add(3'b000, 3'b000, 8'h00, 64'h0,    3'b010, 0, 1, 1, 8'h11, DB|8'h11);
    add(3'b000, 3'b101, 8'h00, 64'h0,    3'b010, 0, 1, 1, 8'h11, DB|8'h11);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b000, 0, 1, 1, 8'h11, DB|8'h11);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b000, 0, 1, 1, 8'h11, DB|8'h11);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b000, 0, 1, 1, 8'h11, DB|8'h11);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b100, 0, 1, 1, 8'h12, DB|8'h12);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b000, 0, 1, 1, 8'h12, DB|8'h12);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b000, 0, 1, 1, 8'h12, DB|8'h12);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b000, 0, 1, 1, 8'h12, DB|8'h12);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b001, 0, 1, 1, 8'h13, DB|8'h13);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b000, 0, 1, 1, 8'h13, DB|8'h13);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b000, 0, 1, 1, 8'h13, DB|8'h13);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b000, 0, 1, 1, 8'h13, DB|8'h13);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b010, 0, 1, 1, 8'h14, DB|8'h14);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b000, 0, 1, 1, 8'h14, DB|8'h14);
    add(3'b000, 3'b111, 8'h00, 64'h0,    3'b000, 0, 0, 1, 8'h14, DB|8'h14);

    // reset values
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst req", {mem_req, read_req, cam_req}, 3'b000);
    chk("rst full", cmd_full, 1'b0);
    chk("rst busy", sched_busy, 1'b0);
    chk("rst drop", drop_cnt, 8'd0);
    chk("rst instr", cmd_instr, 8'd0);
    chk("rst data", cmd_data, 64'd0);
    chk("rst terr", timeout_err, 1'b0);
    rst_n = 1'b1;
    tick();

    foreach (vt[i]) begin
      {v_mem, v_read, v_cam}       = vt[i].v;
      {mem_ack, read_ack, cam_ack} = vt[i].ack;
      instr_in = vt[i].instr;
      data_in  = vt[i].data;
      tick();
      chk($sformatf("row%0d req", i),   {mem_req, read_req, cam_req}, vt[i].ereq);
      chk($sformatf("row%0d full", i),  cmd_full, vt[i].efull);
      chk($sformatf("row%0d busy", i),  sched_busy, vt[i].ebusy);
      chk($sformatf("row%0d drop", i),  drop_cnt, vt[i].edrop);
      chk($sformatf("row%0d instr", i), cmd_instr, vt[i].einstr);
      chk($sformatf("row%0d data", i),  cmd_data, vt[i].edata);
    end
    clear_in();

    // two strobes together: dropped, nothing enqueued
    {v_read, v_cam} = 2'b11;
    tick();
    clear_in();
    chk("multi drop", drop_cnt, 8'd2);
    chk("multi busy", sched_busy, 1'b0);
    repeat (3) tick();
    chk("multi noreq", {mem_req, read_req, cam_req}, 3'b000);
    chk("multi idle", sched_busy, 1'b0);
    for (int n = 0; n < 256; n++) begin
      {v_mem, v_read, v_cam} = 3'b111;
      tick();
    end
    clear_in();
    chk("drop sat", drop_cnt, 8'd255);
    chk("sat busy", sched_busy, 1'b0);

    // reset while a command is in ISSUE with three queued
    for (int n = 0; n < 4; n++) begin
      v_cam = 1'b1;
      instr_in = 8'h20 + 8'(n);
      tick();
    end
    clear_in();
    chk("pre-rst cam_req", cam_req, 1'b1);
    chk("pre-rst full", cmd_full, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("midrst req", {mem_req, read_req, cam_req}, 3'b000);
    chk("midrst full", cmd_full, 1'b0);
    chk("midrst busy", sched_busy, 1'b0);
    chk("midrst drop", drop_cnt, 8'd0);
    chk("midrst instr", cmd_instr, 8'd0);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int n = 0; n < 10; n++) begin
        tick();
        if (mem_req || read_req || cam_req || sched_busy) seen++;
      end
      chk("postrst quiet", seen, 0);
    end
    v_read = 1'b1;
    instr_in = 8'h30;
    data_in = 64'h3030;
    tick();
    clear_in();
    tick();
    chk("new k+1 req", read_req, 1'b0);
    tick();
    chk("new k+2 req", read_req, 1'b1);
    chk("new instr", cmd_instr, 8'h30);
    chk("new data", cmd_data, 64'h3030);
    read_ack = 1'b1;
    tick();
    read_ack = 1'b0;
    chk("new ack req", read_req, 1'b0);
    repeat (2) tick();
    chk("new done busy", sched_busy, 1'b0);

`ifdef MCB_SCHED_TIMEOUT_EN
    begin
      int w = 0;
      int hi = 0;
      v_mem = 1'b1; instr_in = 8'h40;
      tick();
      v_mem = 1'b0; v_cam = 1'b1; instr_in = 8'h41;
      tick();
      clear_in();
      while (!mem_req && w < 10) begin tick(); w++; end
      chk("to wait req", (w < 10), 1'b1);
      while (mem_req && hi < 20) begin hi++; tick(); end
      chk("to req cycles", hi, 8);
      chk("to err set", timeout_err, 1'b1);
      repeat (3) tick();
      chk("to next issue", cam_req, 1'b1);
      chk("to next instr", cmd_instr, 8'h41);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("to err clr", timeout_err, 1'b0);
      repeat (6) tick();
      chk("to still issue", cam_req, 1'b1);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("to clr same edge", timeout_err, 1'b1);
      chk("to req drop", cam_req, 1'b0);
    end
`else
    chk("terr tied", timeout_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
